// File: rtl/csa_resolve_pkg.sv
// ---------------------------------------------------------------------------
// csa_resolve_pkg
// Shared definitions for the carry-save resolver: the controller state type
// and the size helpers that derive result width, chunk count and padded
// operand width from the (width, chunk) parameter pair.
// ---------------------------------------------------------------------------
package csa_resolve_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result width: s + 2c needs two bits more than the operands.
   function automatic int f_ow(input int width);
      return width + 2;
   endfunction

   // Number of chunk-sized slices needed to cover the result width.
   function automatic int f_nch(input int width, input int chunk);
      return (f_ow(width) + chunk - 1) / chunk;
   endfunction

   // Operand width after padding up to a whole number of chunks.
   function automatic int f_pw(input int width, input int chunk);
      return f_nch(width, chunk) * chunk;
   endfunction

endpackage

// File: rtl/csa_resolve_chunk.sv
// ---------------------------------------------------------------------------
// csa_resolve_chunk
// Purely combinational chunk-wide ripple adder used by the resolver to fold
// one slice of the sum and carry vectors per clock.
//   a, b  : chunk-bit addends
//   cin   : carry in from the previous slice
//   sum   : chunk-bit sum
//   cout  : carry out to the next slice
// ---------------------------------------------------------------------------
module csa_resolve_chunk #(
   parameter int chunk = 4
) (
   input  logic [chunk-1:0] a,
   input  logic [chunk-1:0] b,
   input  logic             cin,
   output logic [chunk-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{chunk{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve.sv
// ---------------------------------------------------------------------------
// csa_resolve
// Sequential carry-propagate resolver. Turns a carry-save pair into a plain
// binary value s_in + 2*c_in, resolving `chunk` bits per cycle so the carry
// chain stays short. Valid/ready handshake on both sides; one operation in
// flight at a time.
//   clk, arst : clock (rising edge) and asynchronous active-high reset
//   in_vld    : input pair valid
//   in_rdy    : resolver idle and able to take a pair
//   s_in      : carry-save sum vector
//   c_in      : carry-save carry vector (unshifted, weight 2x)
//   out_vld   : result valid (held until out_rdy)
//   out_rdy   : downstream takes the result
//   result    : s_in + 2*c_in, width+2 bits, unsigned
//   busy      : operation in progress or result waiting
// ---------------------------------------------------------------------------
module csa_resolve
   import csa_resolve_pkg::*;
#(
   parameter int width = 16,
   parameter int chunk = 4
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [width-1:0]     s_in,
   input  logic [width-1:0]     c_in,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [width+1:0]     result,
   output logic                 busy
);

   localparam int OW  = f_ow(width);
   localparam int NCH = f_nch(width, chunk);
   localparam int PW  = f_pw(width, chunk);
   localparam int CW  = $clog2(NCH + 1);

   localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

   state_t            state;
   state_t            state_nxt;
   logic              rdy_en;
   logic [PW-1:0]     a_reg;
   logic [PW-1:0]     b_reg;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     acc_shift;
   logic              carry;
   logic [CW-1:0]     cnt;
   logic [chunk-1:0]  chunk_sum;
   logic              chunk_cout;
   logic              accept;
   logic              last_chunk;

   // in_rdy must stay low while reset is held and only rise at the first
   // clock edge after release, so readiness is gated by a flop that reset
   // clears and the clock sets.
   assign in_rdy     = (state == IDLE) && rdy_en;
   assign accept     = in_rdy && in_vld;
   assign last_chunk = (cnt == LAST_CNT);

   assign out_vld = (state == DONE);
   assign busy    = (state != IDLE);
   assign result  = acc[OW-1:0];

   csa_resolve_chunk #(
      .chunk (chunk)
   ) u_chunk (
      .a    (a_reg[chunk-1:0]),
      .b    (b_reg[chunk-1:0]),
      .cin  (carry),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

   // Each new slice enters at the top of the accumulator; after NCH slices
   // the first one has reached bit 0 and the padded result is aligned.
   always_comb begin
      acc_shift = acc >> chunk;
      acc_shift[PW-1 -: chunk] = chunk_sum;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state  <= IDLE;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)     state_nxt = RUN;
         RUN:     if (last_chunk) state_nxt = DONE;
         DONE:    if (out_rdy)    state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Operands are captured only at the accept edge. The accumulator is not
   // cleared on load because every stale bit is shifted out by the end of
   // RUN. The final carry-out and padding bits are zero for legal inputs
   // and are simply dropped.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         a_reg <= PW'(s_in);
         b_reg <= PW'({c_in, 1'b0});
         carry <= 1'b0;
         cnt   <= '0;
      end else if (state == RUN) begin
         acc   <= acc_shift;
         carry <= chunk_cout;
         a_reg <= a_reg >> chunk;
         b_reg <= b_reg >> chunk;
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: doc/csa_resolve.md
# csa_resolve

Sequential carry-propagate resolver that converts a carry-save pair (sum vector, carry vector) from the carry-save adders into a plain binary result. It computes `s_in + (c_in << 1)` over several cycles, `chunk` bits per cycle, trading latency for a short carry chain. It sits at the end of a CSA reduction tree, with a valid/ready handshake on both sides.

## Interface
Parameters:
- `width`, 16: width of `s_in` and `c_in`; must be ≥ 2.
- `chunk`, 4: bits resolved per cycle; 1 ≤ `chunk` ≤ `width`+2.

Derived:
- OW = `width`+2: result width.
- NCH = ceil(OW/`chunk`): chunk count.
- PW = NCH·`chunk`: padded width.

Ports:
- `clk` in 1: single clock, rising edge.
- `arst` in 1: reset, asynchronous, active-high.
- `in_vld` in 1: input pair valid.
- `in_rdy` out 1: block can accept a pair.
- `s_in` in `width`: carry-save sum vector.
- `c_in` in `width`: carry-save carry vector, unshifted, weight 2× its bit position.
- `out_vld` out 1: result valid.
- `out_rdy` in 1: downstream accepts the result.
- `result` out OW: `s_in` + 2·`c_in`, exact and unsigned.
- `busy` out 1: high in RUN or DONE.

## Operation
- Operands are formed as A = zero-extended `s_in` and B = `c_in` shifted left by one, zero-extended. Both are padded to PW bits.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - `in_rdy`=1.
    - On `in_vld`&`in_rdy`: load A and B into shift registers, clear the carry flop and the chunk counter, go to RUN.
  - RUN:
    - Each cycle, add the low `chunk` bits of A and B plus the carry flop.
    - Shift the chunk sum into the top of the accumulator, shifting it right by `chunk`.
    - Store the carry-out in the carry flop.
    - Shift A and B right by `chunk`.
    - Increment the counter.
    - After the NCH-th chunk, go to DONE.
  - DONE:
    - `out_vld`=1 and `result` = accumulator[OW-1:0], held stable.
    - On `out_rdy`, go to IDLE.
- Input side:
  - `in_rdy`=0 in RUN and DONE.
  - `in_vld` is ignored outside IDLE.
  - Inputs are sampled only at the accept edge, so later changes to them have no effect.
- Padding and overflow:
  - Padding bits and the final carry-out are always zero for legal inputs.
  - The implementation discards them without an assertion requirement.
- Reset:
  - `arst` asserted at any time, including mid-RUN, forces IDLE.
  - `in_rdy`=0 while `arst` is high; `in_rdy`=1 from the first edge after release.
  - `out_vld`=0, `busy`=0, `result`=0, accumulator/A/B/carry/counter = 0.
  - An in-flight operation is discarded with no output.

## Timing
- The input is accepted at edge t (IDLE, `in_vld`=1).
- RUN occupies cycles t+1 … t+NCH.
- `out_vld` rises after edge t+NCH and is high in cycle t+NCH+1.
- Latency is NCH+1 cycles from the accept edge to first `out_vld`.
- If `out_rdy`=1, the handshake completes at edge t+NCH+1. IDLE holds in cycle t+NCH+2, and the next accept is possible at edge t+NCH+2.
- Maximum throughput is one result per NCH+2 cycles.
- Backpressure: `out_vld` and `result` hold for any number of cycles while `out_rdy`=0.
- `out_rdy` is ignored outside DONE.
- `in_vld` and `out_rdy` high simultaneously in DONE: only the output handshake occurs. The input is accepted at the following edge, once in IDLE.
- `chunk` ≥ OW gives NCH=1 and a latency of 2.
- No combinational path from inputs to outputs. All outputs are registered or decoded from state.

## Structure
- Shared package `csa_resolve_pkg`:
  - State enum (IDLE/RUN/DONE).
  - `f_nch(width, chunk)` ceiling-divide function.
  - OW/PW helper constants.
- Sub-module `csa_resolve_chunk`:
  - `chunk`-bit adder with cin/cout.
  - Purely combinational, one instance in the datapath.
- Counter width is clog2(NCH+1).

## Test plan
Default configuration `width`=16, `chunk`=4 (OW=18, NCH=5):
- Reset check: assert `arst` mid-RUN after accepting `s_in`=0x1234, `c_in`=0x0001. Outputs go to 0 immediately. After release, `in_rdy`=1 and no `out_vld` appears for the aborted pair.
- Basic: `s_in`=0x1234, `c_in`=0x0001 accepted at edge t → `out_vld` in cycle t+6 with `result`=0x01236. `in_rdy`=0 in cycles t+1 … t+6.
- Carry chain across chunks:
  - `s_in`=0xFFFE, `c_in`=0x0001 → 0x10000.
  - `s_in`=0xFFFF, `c_in`=0x0000 → 0x0FFFF.
- Maximum: `s_in`=0xFFFF, `c_in`=0xFFFF → 0x2FFFD. Bits 17:16 are 2'b10.
- Backpressure and simultaneous events: hold `out_rdy`=0 for 7 cycles with `in_vld`=1 and a new pair waiting. `result` stays stable and the pair is not accepted. Raise `out_rdy`: the output handshake happens, then the new pair is accepted on the next edge.
- Parameter sweep: `chunk`=1, 3, 18 with 1000 random pairs each, checked against the reference `s+2c`. Latency must be 19, 7 and 2 cycles respectively.
